mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_watchdog.sv | 39 +++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the instruction/data memory arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   STARVE_MAX_DEF     : default number of back-to-back data grants allowed
//                        while a fetch is waiting
//   TIMEOUT_CYCLES_DEF : default watchdog limit (MEM_ARB_TIMEOUT_EN builds)
//   FETCH_BE           : byte enables presented for an instruction fetch
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int         STARVE_MAX_DEF     = 4;
  localparam int         TIMEOUT_CYCLES_DEF = 255;
  localparam logic [3:0] FETCH_BE           = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Counts consecutive cycles with i_busy high and flags the cycle in which the
// TIMEOUT_CYCLES-th busy cycle is reached. Only instantiated when
// MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   i_busy   : arbiter is waiting on the memory
//   o_expire : high during the TIMEOUT_CYCLES-th consecutive busy cycle
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = mem_arb_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of busy cycles already completed, so it reads
  // TIMEOUT_CYCLES-1 during the last permitted cycle.
  assign o_expire = i_busy && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_busy) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a
// load/store port. Data has priority unless a waiting fetch has been passed
// over STARVE_MAX times in a row. One transaction is in flight at a time; the
// memory request and its fields are registered, and completion is reported
// with a one-cycle done pulse plus registered read data.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT_CYCLES busy cycles (err pulse, rdata = 0).
// Ports:
//   clk, rst                         : clock, async active-low reset
//   if_req/if_addr                   : fetch request (held until if_done)
//   if_done/if_rdata                 : fetch completion pulse and word
//   d_req/d_we/d_be/d_addr/d_wdata   : load/store request
//   d_done/d_rdata                   : data completion pulse and load data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : memory request
//   mem_ack/mem_rdata                : memory completion, same-cycle data
//   stall_fetch/stall_mem            : combinational pipeline stalls
//   err                              : watchdog timeout pulse
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX     = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  arb_state_e    r_state;
  logic [SW-1:0] r_starve_cnt;
  logic          r_if_flushed;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_if_done;
  logic [31:0]   r_if_rdata;
  logic          r_d_done;
  logic [31:0]   r_d_rdata;
  logic          r_err;

  logic          w_busy;
  logic          w_expire;
  logic          w_fetch_wins;
  logic          w_data_wins;
  logic          w_complete;
  logic [31:0]   w_rdata;

  assign w_busy       = (r_state != IDLE);
  assign w_fetch_wins = if_req && (!d_req || (r_starve_cnt == SW'(STARVE_MAX)));
  assign w_data_wins  = d_req && !w_fetch_wins;
  // A real ack always beats a same-cycle watchdog expiry.
  assign w_complete   = w_busy && (mem_ack || w_expire);
  assign w_rdata      = mem_ack ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .i_busy  (w_busy),
    .o_expire(w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: reset is asynchronous so an in-flight mem_req drops at once,
      // and the cleared done registers guarantee no stale completion later.
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_if_flushed <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_done     <= 1'b0;
      r_d_rdata    <= '0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values
      // regardless of statement order.
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;

      // Starvation counter only advances on data grants that bypass a fetch.
      if (!if_req) begin
        r_starve_cnt <= '0;
      end else if (r_state == IDLE && w_fetch_wins) begin
        r_starve_cnt <= '0;
      end else if (r_state == IDLE && w_data_wins && r_starve_cnt != SW'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_fetch_wins) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_be     <= FETCH_BE;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= '0;
            r_if_flushed <= 1'b0;
            r_state      <= BUSY_I;
          end else if (w_data_wins) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_be    <= d_be;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_state     <= BUSY_D;
          end
        end

        BUSY_I: begin
          // Once the fetch is withdrawn the in-flight word belongs to a
          // flushed path, even if a new fetch is raised before completion.
          if (!if_req) begin
            r_if_flushed <= 1'b1;
          end
          if (w_complete) begin
            r_mem_req <= 1'b0;
            r_err     <= w_expire && !mem_ack;
            r_state   <= IDLE;
            if (if_req && !r_if_flushed) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_rdata;
            end
          end
        end

        BUSY_D: begin
          if (w_complete) begin
            r_mem_req <= 1'b0;
            r_err     <= w_expire && !mem_ack;
            r_d_done  <= 1'b1;
            r_d_rdata <= w_rdata;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_be      = r_mem_be;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_done     = r_if_done;
  assign if_rdata    = r_if_rdata;
  assign d_done      = r_d_done;
  assign d_rdata     = r_d_rdata;
  assign err         = r_err;
  assign stall_fetch = if_req && !r_if_done;
  assign stall_mem   = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single transactions from
// idle, followed by hand-written sequences for priority, starvation, flush,
// long memory waits / timeout and reset during a transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_fetch;
  logic        stall_mem;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_MAX    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall_fetch(stall_fetch),
    .stall_mem  (stall_mem),
    .err        (err)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    logic        exp_data;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Every step lands 1 ns after the rising edge: registered outputs are
  // settled and new inputs are applied well ahead of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if_req  = v.if_req;
    if_addr = v.if_addr;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_be    = v.d_be;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    tick();
    check($sformatf("v%0d_mem_req", idx), mem_req, 1);
    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    check($sformatf("v%0d_mem_we", idx), mem_we, v.exp_we);
    check($sformatf("v%0d_mem_be", idx), mem_be, v.exp_be);
    check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    tick();
    mem_ack = 1'b0;
    check($sformatf("v%0d_req_drop", idx), mem_req, 0);
    check($sformatf("v%0d_d_done", idx), d_done, v.exp_data);
    check($sformatf("v%0d_if_done", idx), if_done, !v.exp_data);
    if (v.exp_data) check($sformatf("v%0d_d_rdata", idx), d_rdata, v.rdata);
    else            check($sformatf("v%0d_if_rdata", idx), if_rdata, v.rdata);
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check($sformatf("v%0d_quiet", idx), {30'b0, if_done, d_done}, 0);
    check($sformatf("v%0d_no_regrant", idx), mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int  g;
    logic prev;
    logic err_seen;
    int  hi_cycles;
    logic got_done;

    // fetch addr, data fields, rdata, exp_data, exp addr/we/be/wdata
    vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                32'hAAAA_5555, 1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h0000_2004, 32'h0000_0011,
                32'h1357_9BDF, 1'b1, 32'h0000_2004, 1'b0, 4'h3, 32'h0000_0011};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h0000_2008, 32'hCAFE_F00D,
                32'h0000_0055, 1'b1, 32'h0000_2008, 1'b1, 4'h1, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h0000_1004, 1'b1, 1'b1, 4'hC, 32'h0000_200C, 32'h0BAD_C0DE,
                32'h2468_ACE0, 1'b1, 32'h0000_200C, 1'b1, 4'hC, 32'h0BAD_C0DE};
    vecs[4] = '{1'b1, 32'h0000_1008, 1'b1, 1'b0, 4'hF, 32'h0000_2010, 32'h0,
                32'hFEDC_BA98, 1'b1, 32'h0000_2010, 1'b0, 4'hF, 32'h0};

    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // ---- reset state ----
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_fields", mem_addr | mem_wdata | {27'b0, mem_we, mem_be}, 0);
    check("rst_dones", {29'b0, if_done, d_done, err}, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // ---- fetch only, ack in first mem_req cycle ----
    if_req = 1'b1; if_addr = 32'h0000_0100;
    #1 check("f_stall_req", stall_fetch, 1);
    tick();
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h0000_0100);
    check("f_stall_busy", stall_fetch, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 1'b0;
    check("f_if_done", if_done, 1);
    check("f_if_rdata", if_rdata, 32'h0050_0093);
    check("f_stall_done", stall_fetch, 0);
    if_req = 1'b0;
    tick();
    check("f_done_pulse", if_done, 0);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // ---- simultaneous store and fetch ----
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("s_mem_we", mem_we, 1);
    check("s_mem_addr", mem_addr, 32'h0000_2000);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_stall_mem", stall_mem, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0000;
    tick();
    mem_ack = 1'b0;
    check("s_d_done", d_done, 1);
    check("s_gap", mem_req, 0);
    check("s_stall_mem_done", stall_mem, 0);
    d_req = 1'b0;
    tick();
    check("s_fetch_req", mem_req, 1);
    check("s_fetch_addr", mem_addr, 32'h0000_0300);
    check("s_fetch_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0;
    check("s_if_done", if_done, 1);
    check("s_if_rdata", if_rdata, 32'h0000_0013);
    if_req = 1'b0;
    tick();

    // ---- starvation: both held, expect D D D D F D D D D F ----
    if_req = 1'b1; if_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_3000; d_wdata = '0;
    g = 0; prev = 1'b0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      tick();
      if (mem_req && !prev) begin
        check($sformatf("starve_grant%0d", g), mem_addr,
              (g % 5 == 4) ? 32'h0000_0400 : 32'h0000_3000);
        g++;
      end
      prev    = mem_req;
      mem_ack = mem_req;
    end
    check("starve_budget", g, 10);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("starve_idle", mem_req, 0);

    // ---- flush: fetch withdrawn while busy ----
    if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    check("fl_mem_req", mem_req, 1);
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_hold_req%0d", i), mem_req, 1);
      check($sformatf("fl_hold_addr%0d", i), mem_addr, 32'h0000_0500);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    check("fl_no_done", if_done, 0);
    check("fl_req_drop", mem_req, 0);
    tick();
    check("fl_no_done_late", if_done, 0);
    if_req = 1'b1; if_addr = 32'h0000_0200;
    tick();
    check("fl_next_req", mem_req, 1);
    check("fl_next_addr", mem_addr, 32'h0000_0200);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("fl_next_done", if_done, 1);
    check("fl_next_rdata", if_rdata, 32'h1234_5678);
    if_req = 1'b0;
    tick();

    // ---- long memory wait ----
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0600;
`ifdef MEM_ARB_TIMEOUT_EN
    hi_cycles = 0; got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      tick();
      if (mem_req) hi_cycles++;
      if (d_done) begin
        got_done = 1'b1;
        check("to_err", err, 1);
        check("to_rdata", d_rdata, 0);
        check("to_req_drop", mem_req, 0);
        d_req = 1'b0;
      end
    end
    check("to_done_seen", got_done, 1);
    check("to_busy_cycles", hi_cycles, 8);
    tick();
    check("to_err_pulse", err, 0);
    check("to_idle", mem_req, 0);
`else
    err_seen = 1'b0; hi_cycles = 0; got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      err_seen = err_seen | err;
      if (mem_req) hi_cycles++;
      got_done = got_done | d_done;
    end
    check("nt_err", err_seen, 0);
    check("nt_no_done", got_done, 0);
    check("nt_still_waiting", hi_cycles, 20);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0;
    check("nt_d_done", d_done, 1);
    check("nt_d_rdata", d_rdata, 32'h0000_0077);
    d_req = 1'b0;
    tick();
`endif

    // ---- reset in the middle of a data transaction ----
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h6; d_addr = 32'h0000_0700; d_wdata = 32'h5A5A_5A5A;
    tick();
    check("rm_busy", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("rm_req_now", mem_req, 0);
    check("rm_fields_now", mem_addr | mem_wdata | {27'b0, mem_we, mem_be}, 0);
    check("rm_rdata_now", d_rdata, 0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got_done = 1'b0; prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_ack  = (c == 0);
      got_done = got_done | d_done | if_done;
      prev     = prev | mem_req;
    end
    mem_ack = 1'b0;
    check("rm_no_done", got_done, 0);
    check("rm_no_req", prev, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
